// File: rtl/calc_display_pkg.sv
// Shared constants for the calculator display path: glyphs and key-code limits.
// Latency: n/a (constants only).
// Backpressure: n/a.
package calc_display_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Key codes above this are operators and never enter the digit buffer
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// Keypad/ALU-side bus of the display controller: key input, word load, clear, buffer readback.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are accepted every cycle.
interface seven_seg_display_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      KeyPressed;
    logic [3:0]                keyCode;
    logic                      loadEn;
    logic [4*NUM_DIGITS-1:0]   loadData;
    logic                      clearDisp;
    logic [4*NUM_DIGITS-1:0]   displayValue;
    logic                      entryOverflow;

    modport master (
        output KeyPressed, keyCode, loadEn, loadData, clearDisp,
        input  displayValue, entryOverflow
    );

    modport slave (
        input  KeyPressed, keyCode, loadEn, loadData, clearDisp,
        output displayValue, entryOverflow
    );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-high 7-segment glyph decode (full 0-F set).
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module hex_to_seg
    import calc_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Glyph lookup; polarity is handled by the caller
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Calculator-style hex digit buffer with time-multiplexed 7-segment scan and leading-zero blanking.
// Latency: buffer visible 1 cycle after press/strobe; pins lag the scan index by 1 cycle.
// Backpressure: none; every press/strobe is accepted, clear > load > key shift-in.
module seven_seg_display_ctrl
    import calc_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
)(
    input  logic                   CLK,
    input  logic                   RESET,
    seven_seg_display_ctrl_if.slave bus,
    output logic [6:0]             segments,
    output logic [NUM_DIGITS-1:0]  digitSel
);

    localparam int BUF_W = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0]      PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_DIGIT0 = NUM_DIGITS'(1);

    logic                  key_pressed_d;
    logic                  key_press;
    logic [BUF_W-1:0]      buf_q;
    logic                  ovf_q;
    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W+1:0]      nib_base;
    logic [3:0]            cur_nib;
    logic [BUF_W-1:0]      upper_bits;
    logic                  blank;
    logic [6:0]            glyph;
    logic [6:0]            seg_hi;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] sel_q;

    // A held key produces exactly one action: only the rising edge counts
    assign key_press = bus.KeyPressed & ~key_pressed_d;

    // Key level history for edge detection; updates even when a press is discarded
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_pressed_d <= 1'b0;
        end else begin
            key_pressed_d <= bus.KeyPressed;
        end
    end

    // Digit buffer: clear beats load beats key shift-in; overflow flag is sticky until clear/load
    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.clearDisp) begin
            buf_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.loadEn) begin
            buf_q <= bus.loadData;
            ovf_q <= 1'b0;
        end else if (key_press && (bus.keyCode <= KEY_DIGIT_MAX)) begin
            buf_q <= {buf_q[BUF_W-5:0], bus.keyCode};
            if (buf_q[BUF_W-1 -: 4] != 4'd0) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.displayValue  = buf_q;
    assign bus.entryOverflow = ovf_q;

    // Refresh prescaler and scan index: each digit owns REFRESH_DIV consecutive cycles
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_q    <= '0;
            scan_idx <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q    <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Current digit select and leading-zero blanking on the live buffer
    always_comb begin
        nib_base   = {scan_idx, 2'b00};
        cur_nib    = buf_q[nib_base +: 4];
        upper_bits = buf_q >> nib_base;
        blank      = (scan_idx != '0) && (upper_bits == '0);
        seg_hi     = blank ? SEG_BLANK : glyph;
        sel_onehot = SEL_DIGIT0 << scan_idx;
    end

    hex_to_seg u_hex_to_seg (
        .hex (cur_nib),
        .seg (glyph)
    );

    // Pin registers with board polarity applied; reset shows an unblanked '0' on digit 0
    always_ff @(posedge CLK) begin
        if (RESET) begin
            seg_q <= SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
            sel_q <= AN_ACTIVE_LOW ? ~SEL_DIGIT0 : SEL_DIGIT0;
        end else begin
            seg_q <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            sel_q <= AN_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
        end
    end

    assign segments = seg_q;
    assign digitSel = sel_q;

endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
Output-side counterpart of the keypad scanner. It accepts key codes from the keypad path and maintains a NUM_DIGITS hex digit buffer in calculator entry style, where new digits shift in from the right. It also accepts whole-word loads of results and time-multiplexes the buffer onto a common-anode/cathode 7-segment bank by scanning one digit select line at a time. It sits between the keypad/ALU datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, CLK cycles each digit stays selected (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment pins driven low to light
AN_ACTIVE_LOW, 1, 1 = digit select pins driven low to enable

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
KeyPressed  input  1  level; high while a key is held
keyCode  input  4  key code valid while KeyPressed is high (0-9 digits, 10-15 operators)
loadEn  input  1  one-cycle strobe; load loadData into the buffer
loadData  input  4*NUM_DIGITS  packed hex digits, digit 0 in LSBs
clearDisp  input  1  one-cycle strobe; zero the buffer
displayValue  output  4*NUM_DIGITS  current buffer contents
entryOverflow  output  1  sticky; a nonzero MSD was shifted out
segments  output  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
digitSel  output  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW

Behaviour:
- All state changes on rising CLK. RESET is sampled only at clock edges and overrides everything.
- Reset values:
  - buffer = 0, displayValue = 0, entryOverflow = 0.
  - prescaler = 0, scan index = 0, KeyPressed history register = 0.
  - segments = pattern for '0' (7'b0111111 active-high, i.e. 7'b1000000 when SEG_ACTIVE_LOW = 1).
  - digitSel = digit 0 enabled.
- Press detection:
  - keyPress = KeyPressed & ~KeyPressed_d, where KeyPressed_d is the registered previous value.
  - Exactly one action per press, however long the key is held.
- Shift-in: on keyPress with keyCode <= 9:
  - buffer <= {buffer[4*NUM_DIGITS-5:0], keyCode}.
  - If the old MSD is nonzero, set entryOverflow.
  - Press with keyCode 10-15: buffer unchanged. Operator handling is done downstream.
- Priority in a single cycle: clearDisp > loadEn > shift-in.
  - clearDisp: buffer <= 0, entryOverflow <= 0.
  - loadEn: buffer <= loadData, entryOverflow <= 0.
  - A press coinciding with clear/load is discarded, but KeyPressed_d still updates.
- displayValue reflects the new buffer 1 cycle after the strobe/press edge.
- Scanning:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, the scan index advances; NUM_DIGITS-1 wraps to 0.
  - segments/digitSel are registered from the scan index and buffer, so they lag index changes by 1 cycle.
  - Each digit is selected for exactly REFRESH_DIV cycles.
- Leading-zero blanking:
  - A digit i > 0 is blanked (all segments off, digitSel still asserted) when digit i and every higher digit are 0.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the live buffer each cycle.
- Hex decode: full 0-F glyph set (A, b, C, d, E, F). No decimal point.
- Buffer updates mid-scan take effect on the next registered segment update; no tearing beyond 1 cycle.
- A mid-operation RESET aborts the scan and restores all reset values on that edge.

Decomposition:
- Shared package calc_display_pkg:
  - segment glyph constants SEG_0..SEG_F and SEG_BLANK.
  - KEY_DIGIT_MAX = 9.
- One sub-module, hex_to_seg: combinational 4-bit to 7-bit active-high glyph decode. Polarity inversion is applied in the top level.
- Top-level contents:
  - press edge detector
  - buffer/overflow register
  - prescaler
  - scan index
  - blanking logic
  - output registers

Test Plan:
(Run with NUM_DIGITS = 4 and REFRESH_DIV = 4.)
1. Reset, then hold RESET low for 40 cycles -> digitSel cycles 1110, 1101, 1011, 0111, each held exactly 4 cycles. Digit 0 shows 7'b1000000 ('0'); digits 1-3 show 7'b1111111 (blanked).
2. Press keys 1, 2, 3, each holding KeyPressed 10 cycles -> displayValue = 16'h0123 (not repeated shifts). Digit 3 is blanked; digit 2 shows '1' = 7'b1111001.
3. Press 4, 5 after case 2 -> displayValue = 16'h2345 and entryOverflow = 1 (MSD 1 shifted out). Then clearDisp -> 16'h0000, entryOverflow = 0.
4. loadData = 16'hABCF with loadEn, and a press edge in the same cycle -> displayValue = 16'hABCF, key ignored. Scan shows A, b, C, F glyphs.
5. Press keyCode 12 -> displayValue unchanged. loadEn and clearDisp asserted together -> displayValue = 0.
6. Assert RESET during the digit-2 slot with buffer 16'h0042 -> next cycle buffer = 0, digitSel = digit 0, prescaler restarts (4-cycle slot length from there).
